// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR sample-source front end.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } fir_src_state_t;

  localparam int         FIR_TAPS      = 19;
  localparam int         FIR_DW        = 8;
  localparam logic [12:0] FRAME_LEN_NOM = 13'd5000;

  // Saturating 8-bit increment used by the underflow statistic.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = 8'hFF;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_xn_source_sync_fifo.sv
// Single-clock FIFO with registered occupancy count. A write is never
// forwarded to the read side in the same cycle; full/empty come straight
// from the registered count.
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en_s, rd_en_s;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state for pointers, count and storage; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_en_s  = push && !full;
    rd_en_s  = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset empties the FIFO and discards its contents.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/fir_xn_source.sv
// Sample source for the 19-tap FIR: buffers host samples, streams a frame
// at full rate (zero-filling on underflow), then drives FIR_TAPS zeros to
// drain the filter before pulsing done.
module fir_xn_source
  import fir_pkg::*;
#(
  parameter int D_WIDTH  = 8,
  parameter int DEPTH    = 16,
  parameter int PREFILL  = 4,
  parameter int FIR_TAPS = 19,
  parameter int LEN_W    = 13
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   frame_len,
  input  logic               s_valid,
  input  logic [D_WIDTH-1:0] s_data,
  output logic               s_ready,
  output logic [D_WIDTH-1:0] xn_data,
  output logic               xn_valid,
  output logic               busy,
  output logic               done,
  output logic [7:0]         underflow_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(FIR_TAPS + 1);

  fir_src_state_t     state_q, state_d;
  logic [LEN_W-1:0]   frame_len_q, frame_len_d;
  logic [LEN_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [FW-1:0]      flush_cnt_q, flush_cnt_d;
  logic [7:0]         underflow_q, underflow_d;
  logic [D_WIDTH-1:0] xn_data_q, xn_data_d;
  logic               xn_valid_q, xn_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fifo_push_s, fifo_pop_s;
  logic               fifo_full_s, fifo_empty_s;
  logic [D_WIDTH-1:0] fifo_rdata_s;
  logic [CW-1:0]      fifo_count_s;
  logic [LEN_W-1:0]   fill_target_s;
  logic               fill_ok_s;
  logic               emit_s;

  assign s_ready     = !fifo_full_s;
  assign fifo_push_s = s_valid && !fifo_full_s;

  sync_fifo #(
    .WIDTH (D_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .wdata (s_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Streaming begins once the FIFO holds min(PREFILL, frame length) samples.
  always_comb begin
    if (frame_len_q < LEN_W'(PREFILL)) begin
      fill_target_s = frame_len_q;
    end else begin
      fill_target_s = LEN_W'(PREFILL);
    end
    fill_ok_s = (LEN_W'(fifo_count_s) >= fill_target_s);
  end

  // Frame sequencer: outputs are computed for the state being entered so they line up with it.
  always_comb begin
    state_d      = state_q;
    frame_len_d  = frame_len_q;
    sample_cnt_d = sample_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    underflow_d  = underflow_q;
    xn_data_d    = {D_WIDTH{1'b0}};
    xn_valid_d   = 1'b0;
    done_d       = 1'b0;
    emit_s       = 1'b0;
    fifo_pop_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          underflow_d = 8'd0;
          if (frame_len != {LEN_W{1'b0}}) begin
            frame_len_d = frame_len;
            state_d     = FILL;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (fill_ok_s) begin
          state_d      = STREAM;
          emit_s       = 1'b1;
          sample_cnt_d = {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = FILL;
        end
      end
      STREAM: begin
        if (sample_cnt_q == frame_len_q) begin
          state_d     = FLUSH;
          flush_cnt_d = {{(FW-1){1'b0}}, 1'b1};
        end else begin
          emit_s       = 1'b1;
          sample_cnt_d = sample_cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FW'(FIR_TAPS)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + {{(FW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // One frame sample per emit: FIFO head if available, otherwise an underflow zero.
    if (emit_s) begin
      xn_valid_d = 1'b1;
      if (!fifo_empty_s) begin
        fifo_pop_s = 1'b1;
        xn_data_d  = fifo_rdata_s;
      end else begin
        xn_data_d   = {D_WIDTH{1'b0}};
        underflow_d = sat_inc8(underflow_q);
      end
    end else begin
      xn_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      frame_len_q  <= {LEN_W{1'b0}};
      sample_cnt_q <= {LEN_W{1'b0}};
      flush_cnt_q  <= {FW{1'b0}};
      underflow_q  <= 8'd0;
      xn_data_q    <= {D_WIDTH{1'b0}};
      xn_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_len_q  <= frame_len_d;
      sample_cnt_q <= sample_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      underflow_q  <= underflow_d;
      xn_data_q    <= xn_data_d;
      xn_valid_q   <= xn_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign xn_data       = xn_data_q;
  assign xn_valid      = xn_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign underflow_cnt = underflow_q;

endmodule

// File: tb/tb_fir_xn_source.sv
// Scoreboard bench for fir_xn_source: stimulus computes each frame's
// expected output from a queue model of the host sample stream; a
// negedge monitor pops and compares whenever the DUT presents data/done.
module tb_fir_xn_source;

  localparam int DEPTH    = 16;
  localparam int PREFILL  = 4;
  localparam int FIR_TAPS = 19;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [12:0] frame_len;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [7:0]  xn_data;
  logic        xn_valid;
  logic        busy;
  logic        done;
  logic [7:0]  underflow_cnt;

  fir_xn_source dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .frame_len     (frame_len),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .xn_data       (xn_data),
    .xn_valid      (xn_valid),
    .busy          (busy),
    .done          (done),
    .underflow_cnt (underflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       from_fifo;
  } exp_t;

  typedef struct {
    int len;
    int uf;
    int start_cyc;
  } done_t;

  exp_t        exp_q[$];
  done_t       done_q[$];
  logic [7:0]  mq[$];      // host samples not yet assigned to a frame
  int          occ;        // FIFO occupancy as seen on the bus over time
  int          checks;
  int          failures;
  int          cyc;
  int          dones;
  int          vcount;
  int          runs;
  int          last_valid_cyc;
  logic        prev_valid;
  exp_t        me;
  done_t       md;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every presented sample, flush zero and done pulse.
  always @(negedge clk) begin
    if (!n_rst) begin
      vcount     = 0;
      runs       = 0;
      prev_valid = 1'b0;
    end else begin
      if (xn_valid) begin
        chk("busy_in_stream", int'(busy), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          me = exp_q.pop_front();
          chk("xn_data", int'(xn_data), int'(me.d));
          if (me.from_fifo) occ--;
        end
        if (!prev_valid) runs++;
        vcount++;
        last_valid_cyc = cyc;
      end else begin
        chk("zero_when_invalid", int'(xn_data), 0);
      end
      prev_valid = xn_valid;
      chk("s_ready", int'(s_ready), int'(occ < DEPTH));
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          md = done_q.pop_front();
          chk("underflow_cnt", int'(underflow_cnt), md.uf);
          chk("valid_count", vcount, md.len);
          chk("valid_runs", runs, int'(md.len > 0));
          if (md.len > 0) chk("done_gap", cyc - last_valid_cyc, FIR_TAPS + 1);
          else            chk("done_latency", cyc - md.start_cyc, 1);
        end
        vcount = 0;
        runs   = 0;
        dones++;
      end
    end
  end

  // Drive a contiguous s_valid burst; acceptance follows the occupancy model.
  task automatic push_burst(input logic [7:0] vals[$]);
    logic       pend;
    logic [7:0] pend_d;
    pend = 1'b0;
    pend_d = 8'h00;
    foreach (vals[i]) begin
      @(posedge clk); #1;
      if (pend) begin occ++; mq.push_back(pend_d); end
      s_valid = 1'b1;
      s_data  = vals[i];
      @(negedge clk);
      pend   = (occ < DEPTH);
      pend_d = vals[i];
    end
    @(posedge clk); #1;
    if (pend) begin occ++; mq.push_back(pend_d); end
    s_valid = 1'b0;
  endtask

  int last_uf;

  // Issue start and derive the frame's expected output from the sample queue.
  task automatic start_frame(input int len);
    done_t de;
    int    uf;
    @(posedge clk); #1;
    start     = 1'b1;
    frame_len = 13'(len);
    uf = 0;
    for (int i = 0; i < len; i++) begin
      if (mq.size() > 0) exp_q.push_back({mq.pop_front(), 1'b1});
      else begin
        exp_q.push_back({8'h00, 1'b0});
        uf = (uf < 255) ? uf + 1 : 255;
      end
    end
    de.len = len; de.uf = uf; de.start_cyc = cyc;
    done_q.push_back(de);
    last_uf = uf;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int len);
    int target;
    target = dones + 1;
    start_frame(len);
    for (int i = 0; i < len + 100 && dones < target; i++) @(posedge clk);
    if (dones < target) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
      done_q.delete();
    end
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("underflow_hold", int'(underflow_cnt), last_uf);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    chk("rst_xn_data", int'(xn_data), 0);
    chk("rst_xn_valid", int'(xn_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_underflow", int'(underflow_cnt), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    exp_q.delete();
    done_q.delete();
    mq.delete();
    occ = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v[$];
    checks = 0; failures = 0; cyc = 0; dones = 0; occ = 0;
    vcount = 0; runs = 0; last_valid_cyc = 0; prev_valid = 1'b0; last_uf = 0;
    n_rst = 1'b1; start = 1'b0; frame_len = 13'd0; s_valid = 1'b0; s_data = 8'h00;
    #2 n_rst = 1'b0;
    #2;
    chk("por_xn_valid", int'(xn_valid), 0);
    chk("por_busy", int'(busy), 0);
    chk("por_s_ready", int'(s_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 n_rst = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal frame
    v = {8'h7F, 8'h80};
    for (int i = 1; i <= 14; i++) v.push_back(8'(i));
    push_burst(v);
    run_frame(16);

    // Underflow: four real samples followed by four zeros
    v = {8'h11, 8'h12, 8'h13, 8'h14};
    push_burst(v);
    run_frame(8);

    // Reset while idle with a non-zero underflow statistic
    do_reset();

    // Backpressure: 20 offered, 16 accepted
    v = {};
    for (int i = 0; i < 20; i++) v.push_back(8'(8'h40 + i));
    push_burst(v);
    run_frame(16);

    // Zero-length frame keeps FIFO contents for the next frame
    v = {8'hA0, 8'hA1, 8'hA2};
    push_burst(v);
    run_frame(0);
    run_frame(3);

    // Underflow counter saturation
    v = {8'h21, 8'h22, 8'h23, 8'h24};
    push_burst(v);
    run_frame(300);

    // Abort mid-stream, then a fresh frame
    v = {};
    for (int i = 0; i < 16; i++) v.push_back(8'(8'h60 + i));
    push_burst(v);
    start_frame(16);
    for (int i = 0; i < 100 && vcount < 5; i++) @(posedge clk);
    chk("abort_reached_sample5", vcount, 5);
    do_reset();
    repeat (3) @(posedge clk);
    v = {8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    push_burst(v);
    run_frame(5);

    // Randomized frames
    for (int it = 0; it < 25; it++) begin
      int len;
      int npush;
      int need;
      len   = int'($urandom_range(0, 24));
      npush = int'($urandom_range(0, DEPTH - mq.size()));
      need  = (len < PREFILL) ? len : PREFILL;
      if (mq.size() + npush < need) npush = need - mq.size();
      v = {};
      for (int k = 0; k < npush; k++) v.push_back(8'($urandom));
      if (npush > 0) push_burst(v);
      run_frame(len);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_xn_source.md
Name: fir_xn_source

Overview:
- Sample-source front end that drives the 19-tap symmetric FIR input (xn_data, 8-bit signed, one sample per clk).
- Accepts samples from a host or test controller over a valid/ready stream and buffers them in a FIFO.
- On start, emits a frame of frame_len samples at full rate, then emits FIR_TAPS zeros so the filter pipeline drains to a known state.
- Reports completion and underflow statistics.

Parameters:
- D_WIDTH, 8, sample width in bits (signed two's complement).
- DEPTH, 16, FIFO depth in entries; must be a power of 2 and at least 2.
- PREFILL, 4, minimum FIFO occupancy before streaming begins; must satisfy 1 <= PREFILL <= DEPTH.
- FIR_TAPS, 19, number of zero samples driven in the flush phase.
- LEN_W, 13, width of frame_len (max 8191; nominal frame is 5000).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  single-cycle frame start request; honoured only in IDLE.
- frame_len  input  LEN_W  number of frame samples; latched on an accepted start.
- s_valid  input  1  host sample valid.
- s_data  input  D_WIDTH  host sample.
- s_ready  output  1  FIFO can accept a sample.
- xn_data  output  D_WIDTH  registered sample to the FIR input.
- xn_valid  output  1  registered; high while xn_data carries a frame sample.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of frame.
- underflow_cnt  output  8  count of underflow zeros in the current or last frame; saturates at 255.

Behaviour:
- Reset (async, n_rst low):
  - xn_data=0, xn_valid=0, busy=0, done=0, underflow_cnt=0.
  - FIFO read/write pointers and count cleared; contents discarded.
  - FSM enters IDLE; s_ready=1 immediately after reset.
  - Reset asserted mid-frame aborts the frame with no done pulse.
- FIFO:
  - Push on s_valid&&s_ready.
  - s_ready = (count != DEPTH), derived from the registered count with no pop bypass. A pop in the same cycle does not raise s_ready.
  - Simultaneous push and pop: count unchanged, pointers each advance.
  - Push to an empty FIFO is not forwarded in the same cycle; a sample written at edge t is poppable at edge t+1 at the earliest.
  - Pushes are accepted in every state, including IDLE.
- FSM states: IDLE, FILL, STREAM, FLUSH, DONE.
  - IDLE: xn_data=0, xn_valid=0.
    - start=1 and frame_len!=0: latch frame_len, clear underflow_cnt, go to FILL.
    - start=1 and frame_len==0: clear underflow_cnt, go to DONE.
    - start while busy is ignored.
  - FILL: xn_data=0, xn_valid=0. Go to STREAM when count >= min(PREFILL, frame_len_q).
  - STREAM: each cycle, one frame sample is registered onto xn_data with xn_valid=1.
    - FIFO non-empty: pop the head onto xn_data.
    - FIFO empty: drive 0 and increment underflow_cnt (saturating). The underflow zero counts as a frame sample, so the frame rate stays fixed.
    - A sample counter increments per emitted sample. When the counter reaches frame_len_q, go to FLUSH.
    - Exactly frame_len_q consecutive cycles have xn_valid=1.
  - FLUSH: drive xn_data=0, xn_valid=0 for exactly FIR_TAPS cycles, then go to DONE. No pops occur.
  - DONE: done=1 for one cycle, then IDLE. Leftover FIFO samples are retained for the next frame.
- Output timing:
  - xn_data and xn_valid are registered.
  - The first frame sample appears the cycle after the FILL-to-STREAM transition edge.
  - The done pulse occurs FIR_TAPS+1 cycles after the last xn_valid cycle.
- Counters:
  - Sample counter is LEN_W bits and compared for equality with frame_len_q; no wrap is possible.
  - underflow_cnt holds its value after the frame until the next accepted start.
- Data is passed bit-exact; no scaling or saturation.

Decomposition:
- Shared package fir_pkg:
  - state enum fir_src_state_t {IDLE, FILL, STREAM, FLUSH, DONE};
  - constants FIR_TAPS=19, FIR_DW=8, FRAME_LEN_NOM=13'd5000.
- One sub-module: sync_fifo, parameterised by width and depth, with push/pop/full/empty/count ports. The FSM, counters and output registers live in fir_xn_source.

Test Plan:
- Reset: assert n_rst low mid-idle -> xn_data=0x00, xn_valid=0, busy=0, done=0, underflow_cnt=0, s_ready=1.
- Nominal frame: push 16 samples 0x7F,0x80,0x01..0x0E, then start with frame_len=16.
  - xn_valid high for exactly 16 consecutive cycles carrying those values in order.
  - Then 19 cycles of 0x00 with xn_valid=0, then a one-cycle done pulse; underflow_cnt=0.
- Underflow: PREFILL=4, push 4 samples 0x11..0x14, start with frame_len=8.
  - Output 0x11..0x14 followed by four 0x00 samples, all with xn_valid=1.
  - underflow_cnt=4, then flush and done.
- Backpressure: in IDLE, hold s_valid=1 for 20 cycles -> 16 samples accepted, s_ready=0 from the 17th cycle.
  - After start, s_ready returns high the cycle after the first pop.
  - No sample is lost or duplicated (check xn_data sequence).
- Zero length: start with frame_len=0 -> done pulses on the cycle after start; xn_valid never asserted; FIFO contents unchanged.
- Abort: assert n_rst during STREAM (sample 5 of 16) -> xn_data/xn_valid/busy drop to 0 asynchronously; no done pulse.
  - After release, a fresh frame with new samples streams correctly from an empty FIFO.
